// File: rtl/cbfp_min_fin_seq.sv
// rtl/cbfp_min_fin_seq.sv - CBFP min-finish sequencer: per-group strobe, block done, stall/abort/re-arm
module cbfp_min_fin_seq #(
  parameter int GROUP_LEN  = 4,
  parameter int NUM_GROUPS = 8,
  localparam int GRP_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int BEAT_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             valid_in,
  input  logic             abort,
  output logic             min_fin_en,
  output logic [GRP_W-1:0] grp_idx,
  output logic             busy,
  output logic             done,
  output logic             start_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(GROUP_LEN - 1);
  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NUM_GROUPS - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [GRP_W-1:0]  grp_cnt_q, grp_cnt_d;

  logic              min_fin_en_q, min_fin_en_d;
  logic [GRP_W-1:0]  grp_idx_q, grp_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_err_q, start_err_d;

  logic              run_beat;
  logic              beat_last;
  logic              grp_last;
  logic              grp_end;
  logic              blk_end;
  logic              rearm;

  // Event decode: a counted beat, the group-closing beat, the block-closing beat and a legal re-arm
  always_comb begin
    run_beat  = (state_q == RUN) && valid_in;
    beat_last = (beat_cnt_q == BEAT_LAST);
    grp_last  = (grp_cnt_q == GRP_LAST);
    grp_end   = run_beat && beat_last;
    blk_end   = grp_end && grp_last;
    rearm     = blk_end && start;
  end

  // State, counters and registered outputs; asynchronous reset drops any pending strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      grp_cnt_q    <= '0;
      min_fin_en_q <= 1'b0;
      grp_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      min_fin_en_q <= min_fin_en_d;
      grp_idx_q    <= grp_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_err_q  <= start_err_d;
    end
  end

  // Next state and counters; abort wins over start and over a group end in the same cycle
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    if (abort) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      grp_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = RUN;
            beat_cnt_d = '0;
            grp_cnt_d  = '0;
          end
        end
        RUN: begin
          if (valid_in) begin
            if (beat_last) begin
              beat_cnt_d = '0;
              if (grp_last) begin
                grp_cnt_d = '0;
                // a start on the block-closing beat keeps the sequencer running with fresh counters
                state_d   = start ? RUN : IDLE;
              end else begin
                grp_cnt_d = grp_cnt_q + GRP_W'(1);
              end
            end else begin
              beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
          end
        end
        default: begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          grp_cnt_d  = '0;
        end
      endcase
    end
  end

  // Output next values; strobes are one-cycle, grp_idx only updates on a group end
  always_comb begin
    min_fin_en_d = 1'b0;
    done_d       = 1'b0;
    start_err_d  = 1'b0;
    grp_idx_d    = grp_idx_q;
    busy_d       = (state_d == RUN);
    if (!abort) begin
      min_fin_en_d = grp_end;
      done_d       = blk_end;
      start_err_d  = (state_q == RUN) && start && !rearm;
      if (grp_end) begin
        grp_idx_d = grp_cnt_q;
      end
    end
  end

  assign min_fin_en = min_fin_en_q;
  assign grp_idx    = grp_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign start_err  = start_err_q;

endmodule
